// File: rtl/cu_pkg.sv
// Shared constants for the RV32I control unit: instType codes, opcodes,
// branch fun3 codes, FSM state enum and control-word bit positions.
package cu_pkg;

  localparam logic [3:0] IT_LOAD  = 4'd0;
  localparam logic [3:0] IT_IMM   = 4'd1;
  localparam logic [3:0] IT_STORE = 4'd2;
  localparam logic [3:0] IT_REG   = 4'd3;
  localparam logic [3:0] IT_LUI   = 4'd4;
  localparam logic [3:0] IT_AUIPC = 4'd5;
  localparam logic [3:0] IT_BRNCH = 4'd6;
  localparam logic [3:0] IT_JALR  = 4'd7;
  localparam logic [3:0] IT_JAL   = 4'd8;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_REG   = 7'h33;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_BRNCH = 7'h63;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_JAL   = 7'h6F;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  // addi x0,x0,0
  localparam logic [22:0] NOP_CWORD = 23'h000001;

  localparam int CW_RS2 = 18;
  localparam int CW_RS1 = 13;
  localparam int CW_RD  = 8;
  localparam int CW_F7  = 7;
  localparam int CW_F3  = 4;
  localparam int CW_IT  = 0;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: ir (32) in, imm (32) out, sign-extended per opcode
// format (I/S/B/U/J); unknown opcodes give 0.
module imm_gen
  import cu_pkg::*;
(
  input  logic [31:0] ir,
  output logic [31:0] imm
);

  logic [6:0] opc;

  assign opc = ir[6:0];

  always_comb begin
    imm = '0;
    unique case (1'b1)
      (opc == OP_LOAD),
      (opc == OP_IMM),
      (opc == OP_JALR):
        imm = {{20{ir[31]}}, ir[31:20]};
      (opc == OP_STORE):
        imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      (opc == OP_BRNCH):
        imm = {{19{ir[31]}}, ir[31], ir[7],
               ir[30:25], ir[11:8], 1'b0};
      (opc == OP_LUI),
      (opc == OP_AUIPC):
        imm = {ir[31:12], 12'b0};
      (opc == OP_JAL):
        imm = {{11{ir[31]}}, ir[31], ir[19:12],
               ir[20], ir[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/sequencing unit for an RV32I datapath.
// Ports: clk, rst (sync, active-high); imem_req/imem_addr/imem_rdata/
// imem_valid fetch port; r_for_pc/r_rs2 register operands; cword, pc,
// imm, retire_cnt, halted outputs. Optional macro CU_ILLEGAL_HALT_EN:
// illegal instructions halt the unit instead of being skipped.
module control_unit
  import cu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic [31:0] r_for_pc,
  input  logic [31:0] r_rs2,
  output logic [22:0] cword,
  output logic [31:0] pc,
  output logic [31:0] imm,
  output logic [31:0] retire_cnt,
  output logic        halted
);

  state_t      state_q, state_d;
  logic [31:0] ir_q;
  logic [31:0] pc_q;
  logic [31:0] retire_q;
  logic [31:0] imm_raw;
  logic [31:0] tgt;
  logic [31:0] next_pc;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [3:0]  itype;
  logic        legal;
  logic        taken;
  logic        fun7;

  assign opc = ir_q[6:0];
  assign f3  = ir_q[14:12];

  imm_gen u_imm_gen (
    .ir  (ir_q),
    .imm (imm_raw)
  );

  always_comb begin
    itype = IT_IMM;
    legal = 1'b1;
    unique case (1'b1)
      (opc == OP_LOAD): begin
        itype = IT_LOAD;
        legal = (f3 != 3'b011) && (f3 < 3'b110);
      end
      (opc == OP_IMM):   itype = IT_IMM;
      (opc == OP_STORE): begin
        itype = IT_STORE;
        legal = (f3 <= 3'b010);
      end
      (opc == OP_REG):   itype = IT_REG;
      (opc == OP_LUI):   itype = IT_LUI;
      (opc == OP_AUIPC): itype = IT_AUIPC;
      (opc == OP_BRNCH): begin
        itype = IT_BRNCH;
        legal = (f3 != 3'b010) && (f3 != 3'b011);
      end
      (opc == OP_JALR):  itype = IT_JALR;
      (opc == OP_JAL):   itype = IT_JAL;
      default:           legal = 1'b0;
    endcase
    if (ir_q[1:0] != 2'b11) legal = 1'b0;
  end

  // fun7 only distinguishes add/sub, srl/sra and srli/srai
  assign fun7 = ir_q[30] &
                ((itype == IT_REG) |
                 ((itype == IT_IMM) && (f3 == 3'b101)));

  always_comb begin
    taken = 1'b0;
    unique case (f3)
      F3_BEQ:  taken = (r_for_pc == r_rs2);
      F3_BNE:  taken = (r_for_pc != r_rs2);
      F3_BLT:  taken = ($signed(r_for_pc) < $signed(r_rs2));
      F3_BGE:  taken = ($signed(r_for_pc) >= $signed(r_rs2));
      F3_BLTU: taken = (r_for_pc < r_rs2);
      F3_BGEU: taken = (r_for_pc >= r_rs2);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    tgt = pc_q + 32'd4;
    if (legal) begin
      unique case (1'b1)
        (itype == IT_JAL):
          tgt = pc_q + imm_raw;
        (itype == IT_JALR):
          tgt = (r_for_pc + imm_raw) & ~32'd1;
        (itype == IT_BRNCH) && taken:
          tgt = pc_q + imm_raw;
        default: ;
      endcase
    end
    next_pc = tgt & ~32'd3;
  end

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    cword    = NOP_CWORD;
    imm      = '0;
    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        if (legal) begin
          cword = '0;
          cword[CW_RS2 +: 5] = ir_q[24:20];
          cword[CW_RS1 +: 5] = ir_q[19:15];
          cword[CW_RD  +: 5] = ir_q[11:7];
          cword[CW_F7]       = fun7;
          cword[CW_F3  +: 3] = f3;
          cword[CW_IT  +: 4] = itype;
          imm = imm_raw;
        end
`ifdef CU_ILLEGAL_HALT_EN
        else begin
          state_d = HALT;
        end
`endif
      end
      default: begin
`ifdef CU_ILLEGAL_HALT_EN
        state_d = HALT;
`else
        state_d = FETCH;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      ir_q     <= '0;
      pc_q     <= RESET_PC;
      retire_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == FETCH) && imem_valid)
        ir_q <= imem_rdata;
      if ((state_q == EXEC) && (state_d == FETCH))
        pc_q <= next_pc;
      if ((state_q == EXEC) && legal)
        retire_q <= retire_q + 32'd1;
    end
  end

  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign retire_cnt = retire_q;

`ifdef CU_ILLEGAL_HALT_EN
  assign halted = (state_q == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: directed and randomized instruction
// streams checked against a behavioural RV32I sequencing model.
module tb_control_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] r_for_pc;
  logic [31:0] r_rs2;
  logic [22:0] cword;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [31:0] retire_cnt;
  logic        halted;

  int checks = 0;
  int fails  = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic [22:0] obs_cw;
  logic [31:0] obs_imm;

  control_unit #(.RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .r_for_pc   (r_for_pc),
    .r_rs2      (r_rs2),
    .cword      (cword),
    .pc         (pc),
    .imm        (imm),
    .retire_cnt (retire_cnt),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_model(
    input  logic [31:0] ir,
    input  logic [31:0] cur_pc,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [22:0] cw,
    output logic [31:0] im,
    output logic [31:0] npc,
    output bit          ok
  );
    logic [31:0] op, f3, rd, r1, r2, f7, t, tgt, sx, full;
    bit tk;
    op = ir & 32'h7F;
    f3 = (ir >> 12) & 32'd7;
    rd = (ir >> 7) & 32'd31;
    r1 = (ir >> 15) & 32'd31;
    r2 = (ir >> 20) & 32'd31;
    sx = ir[31] ? 32'hFFFF_FFFF : 32'h0;
    ok = 1'b1;
    t  = 0;
    im = 0;
    tk = 1'b0;
    case (op)
      32'h03: begin
        t = 0; ok = (f3 != 3) && (f3 < 6);
        im = (sx << 12) | (ir >> 20);
      end
      32'h13: begin t = 1; im = (sx << 12) | (ir >> 20); end
      32'h23: begin
        t = 2; ok = (f3 <= 2);
        im = (sx << 12) | ((ir >> 25) << 5) | rd;
      end
      32'h33: t = 3;
      32'h37: begin t = 4; im = ir & 32'hFFFF_F000; end
      32'h17: begin t = 5; im = ir & 32'hFFFF_F000; end
      32'h63: begin
        t = 6; ok = (f3 != 2) && (f3 != 3);
        im = (sx << 12) | (((ir >> 7) & 1) << 11) |
             (((ir >> 25) & 63) << 5) | (((ir >> 8) & 15) << 1);
      end
      32'h67: begin t = 7; im = (sx << 12) | (ir >> 20); end
      32'h6F: begin
        t = 8;
        im = (sx << 20) | (ir & 32'h000F_F000) |
             (((ir >> 20) & 1) << 11) | (((ir >> 21) & 1023) << 1);
      end
      default: ok = 1'b0;
    endcase
    f7 = ((t == 3) || (t == 1 && f3 == 5)) ? ((ir >> 30) & 1) : 0;
    case (f3)
      0: tk = (a == b);
      1: tk = (a != b);
      4: tk = ($signed(a) < $signed(b));
      5: tk = ($signed(a) >= $signed(b));
      6: tk = (a < b);
      7: tk = (a >= b);
      default: tk = 1'b0;
    endcase
    tgt = cur_pc + 4;
    if (t == 8) tgt = cur_pc + im;
    if (t == 7) tgt = (a + im) & ~32'd1;
    if (t == 6 && tk) tgt = cur_pc + im;
    full = r2 * 262144 + r1 * 8192 + rd * 256 + f7 * 128 + f3 * 16 + t;
    cw = full[22:0];
    if (!ok) begin
      cw  = 23'h000001;
      im  = 0;
      tgt = cur_pc + 4;
    end
    npc = tgt & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd,
                                        input logic [31:0] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6F};
  endfunction

  // One full instruction: wt idle fetch cycles, response, EXEC, retire.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] a,
                           input logic [31:0] b, input int wt,
                           input bit noise);
    logic [22:0] ecw;
    logic [31:0] eim, enpc;
    bit ok;
    ref_model(ins, m_pc, a, b, ecw, eim, enpc, ok);
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    for (int i = 0; i < wt; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || cword !== 23'h1 ||
          pc !== m_pc || retire_cnt !== m_ret || imm !== 32'h0) begin
        fails++;
        $display("FAIL wait_fetch req=%b addr=%h cw=%h pc=%h ret=%0d want addr/pc=%h ret=%0d",
                 imem_req, imem_addr, cword, pc, retire_cnt, m_pc, m_ret);
      end
      @(posedge clk); #1;
    end
    imem_valid = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== m_pc || cword !== 23'h1) begin
      fails++;
      $display("FAIL fetch req=%b addr=%h cw=%h want req=1 addr=%h cw=000001",
               imem_req, imem_addr, cword, m_pc);
    end
    @(posedge clk); #1;
    imem_valid = noise;
    imem_rdata = $urandom;
    r_for_pc   = a;
    r_rs2      = b;
    @(negedge clk);
    obs_cw  = cword;
    obs_imm = imm;
    checks++;
    if (cword !== ecw || imm !== eim || imem_req !== 1'b0 ||
        halted !== 1'b0) begin
      fails++;
      $display("FAIL exec ir=%h cw=%h imm=%h req=%b want cw=%h imm=%h req=0",
               ins, cword, imm, imem_req, ecw, eim);
    end
    @(posedge clk); #1;
    imem_valid = 1'b0;
`ifdef CU_ILLEGAL_HALT_EN
    if (!ok) enpc = m_pc;
`endif
    if (ok) m_ret = m_ret + 1;
    m_pc = enpc;
    checks++;
    if (pc !== m_pc || retire_cnt !== m_ret) begin
      fails++;
      $display("FAIL retire ir=%h pc=%h ret=%0d want pc=%h ret=%0d",
               ins, pc, retire_cnt, m_pc, m_ret);
    end
  endtask

  task automatic goto_pc(input logic [31:0] tgt);
    run_instr(enc_j(5'd0, tgt - m_pc), 32'h0, 32'h0, 0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    r_for_pc = 0;
    r_rs2 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    imem_valid = 1'b0;
    checks++;
    if (pc !== 32'h0 || retire_cnt !== 32'h0 || halted !== 1'b0) begin
      fails++;
      $display("FAIL reset_regs pc=%h ret=%0d halted=%b want 0/0/0",
               pc, retire_cnt, halted);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || cword !== 23'h1 ||
        imm !== 32'h0) begin
      fails++;
      $display("FAIL reset_outs req=%b addr=%h cw=%h imm=%h want 1/0/000001/0",
               imem_req, imem_addr, cword, imm);
    end
    @(posedge clk); #1;
    m_pc = 32'h0;
    m_ret = 32'h0;
  endtask

  task automatic test_addi;
    run_instr(32'h0050_0093, 32'h0, 32'h0, 0, 1'b0);
    checks++;
    if (obs_cw !== 23'h140101 || obs_imm !== 32'd5 || pc !== 32'h4 ||
        retire_cnt !== 32'd1) begin
      fails++;
      $display("FAIL addi cw=%h imm=%h pc=%h ret=%0d want 140101/5/4/1",
               obs_cw, obs_imm, pc, retire_cnt);
    end
  endtask

  task automatic test_branch;
    goto_pc(32'h10);
    run_instr(32'h0000_0463, 32'h0, 32'h0, 0, 1'b0);
    checks++;
    if (pc !== 32'h18) begin
      fails++;
      $display("FAIL beq_taken pc=%h want 00000018", pc);
    end
    goto_pc(32'h10);
    run_instr(32'h0000_0463, 32'h0, 32'h1, 0, 1'b0);
    checks++;
    if (pc !== 32'h14) begin
      fails++;
      $display("FAIL beq_not_taken pc=%h want 00000014", pc);
    end
  endtask

  task automatic test_jal;
    goto_pc(32'h20);
    run_instr(32'h0100_00EF, 32'h0, 32'h0, 0, 1'b0);
    checks++;
    if (obs_cw[3:0] !== 4'd8 || obs_cw[12:8] !== 5'd1 ||
        obs_imm !== 32'd16 || pc !== 32'h30) begin
      fails++;
      $display("FAIL jal type=%0d rd=%0d imm=%h pc=%h want 8/1/10/30",
               obs_cw[3:0], obs_cw[12:8], obs_imm, pc);
    end
  endtask

  task automatic test_jalr;
    run_instr(32'h0002_8067, 32'h103, 32'h0, 0, 1'b0);
    checks++;
    if (pc !== 32'h100) begin
      fails++;
      $display("FAIL jalr pc=%h want 00000100", pc);
    end
  endtask

  task automatic test_wait;
    logic [31:0] ret0;
    ret0 = m_ret;
    run_instr(32'h0050_0093, 32'h0, 32'h0, 3, 1'b0);
    checks++;
    if (pc !== 32'h104 || retire_cnt !== ret0 + 1) begin
      fails++;
      $display("FAIL wait_done pc=%h ret=%0d want 104/%0d",
               pc, retire_cnt, ret0 + 1);
    end
  endtask

  task automatic test_wrap;
    run_instr(32'h0002_8067, 32'hFFFF_FFFE, 32'h0, 0, 1'b0);
    run_instr(32'h0050_0093, 32'h0, 32'h0, 1, 1'b0);
    checks++;
    if (pc !== 32'h0) begin
      fails++;
      $display("FAIL pc_wrap pc=%h want 00000000", pc);
    end
  endtask

  task automatic test_illegal;
    logic [31:0] ret0;
    goto_pc(32'h40);
    ret0 = m_ret;
    run_instr(32'hFFFF_FFFF, 32'h0, 32'h0, 0, 1'b0);
`ifdef CU_ILLEGAL_HALT_EN
    for (int i = 0; i < 4; i++) begin
      imem_valid = 1'b1;
      imem_rdata = 32'h0050_0093;
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h40 ||
          cword !== 23'h1 || retire_cnt !== ret0) begin
        fails++;
        $display("FAIL halt halted=%b req=%b pc=%h cw=%h ret=%0d want 1/0/40/000001/%0d",
                 halted, imem_req, pc, cword, retire_cnt, ret0);
      end
      @(posedge clk); #1;
    end
    imem_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_pc = 32'h0;
    m_ret = 32'h0;
    checks++;
    if (halted !== 1'b0 || pc !== 32'h0 || imem_req !== 1'b1) begin
      fails++;
      $display("FAIL halt_exit halted=%b pc=%h req=%b want 0/0/1",
               halted, pc, imem_req);
    end
`else
    checks++;
    if (pc !== 32'h44 || retire_cnt !== ret0) begin
      fails++;
      $display("FAIL illegal_skip pc=%h ret=%0d want 44/%0d",
               pc, retire_cnt, ret0);
    end
    begin
      logic [31:0] bad [5];
      bad[0] = 32'h0000_2063;
      bad[1] = 32'h0000_3003;
      bad[2] = 32'h0000_3023;
      bad[3] = 32'h0000_0073;
      bad[4] = 32'h0000_000F;
      foreach (bad[k]) run_instr(bad[k], $urandom, $urandom, k % 2, 1'b0);
    end
    checks++;
    if (pc !== 32'h58 || retire_cnt !== ret0) begin
      fails++;
      $display("FAIL illegal_set pc=%h ret=%0d want 58/%0d",
               pc, retire_cnt, ret0);
    end
`endif
  endtask

  task automatic test_reset_midfetch;
    imem_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'h0000_0073;
    @(posedge clk); #1;
    rst = 1'b0;
    imem_valid = 1'b0;
    m_pc = 32'h0;
    m_ret = 32'h0;
    checks++;
    if (pc !== 32'h0 || retire_cnt !== 32'h0 || imem_req !== 1'b1) begin
      fails++;
      $display("FAIL reset_fetch pc=%h ret=%0d req=%b want 0/0/1",
               pc, retire_cnt, imem_req);
    end
    run_instr(32'h0050_0093, 32'h0, 32'h0, 2, 1'b0);
    imem_valid = 1'b1;
    imem_rdata = 32'h0100_00EF;
    @(posedge clk); #1;
    rst = 1'b1;
    imem_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_pc = 32'h0;
    m_ret = 32'h0;
    checks++;
    if (pc !== 32'h0 || retire_cnt !== 32'h0 || cword !== 23'h1) begin
      fails++;
      $display("FAIL reset_exec pc=%h ret=%0d cw=%h want 0/0/000001",
               pc, retire_cnt, cword);
    end
  endtask

  task automatic test_random;
    logic [6:0]  ops [9];
    logic [31:0] ins, a, b, xi, xn;
    logic [22:0] xc;
    bit ok;
    ops[0] = 7'h03; ops[1] = 7'h13; ops[2] = 7'h23;
    ops[3] = 7'h33; ops[4] = 7'h37; ops[5] = 7'h17;
    ops[6] = 7'h63; ops[7] = 7'h67; ops[8] = 7'h6F;
    for (int n = 0; n < 300; n++) begin
      do begin
        int sel;
        sel = $urandom_range(0, 10);
        ins = $urandom;
        if (sel < 9) ins[6:0] = ops[sel];
        else if (sel == 10) ins[6:0] = ($urandom_range(0, 1) == 0) ? 7'h73 : 7'h0F;
        a = $urandom;
        b = ($urandom_range(0, 2) == 0) ? a : $urandom;
        ref_model(ins, m_pc, a, b, xc, xi, xn, ok);
`ifdef CU_ILLEGAL_HALT_EN
      end while (!ok);
`else
      end while (1'b0);
`endif
      run_instr(ins, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst = 1'b1;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    r_for_pc = 32'h0;
    r_rs2 = 32'h0;
    m_pc = 32'h0;
    m_ret = 32'h0;
    test_reset;
    test_addi;
    test_branch;
    test_jal;
    test_jalr;
    test_wait;
    test_wrap;
    test_illegal;
    test_reset_midfetch;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
